// File: rtl/pwm_sar_scan.sv
// Multi-channel SAR ADC controller driving a PWM-filtered DAC: round-robins over enabled
// mux channels, samples, resolves WIDTH bits against an external comparator, tags results.
module pwm_sar_scan #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned SETTLE     = 10000,
  parameter int unsigned SAMPLE_CYC = 16,
  localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic                cmp,
  output logic [CH_W-1:0]     mux_sel,
  output logic                sample,
  output logic [WIDTH-1:0]    dac_code,
  output logic                pwm_out,
  output logic                busy,
  output logic                valid,
  output logic [WIDTH-1:0]    result,
  output logic [CH_W-1:0]     result_ch
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SMP_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  localparam logic [WIDTH-1:0] Msb = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [SET_W-1:0] SetReload = SET_W'(SETTLE - 1);
  localparam logic [SMP_W-1:0] SmpReload = SMP_W'(SAMPLE_CYC - 1);
  localparam logic [CH_W-1:0]  PtrReset = CH_W'(CHANNELS - 1);

  typedef enum logic [1:0] {StIdle, StSample, StConv, StDone} state_e;

  state_e            state_q;
  logic [CH_W-1:0]   ptr_q;
  logic [WIDTH-1:0]  bit_q;
  logic [WIDTH-1:0]  work_q;
  logic [WIDTH-1:0]  work_nxt;
  logic [SET_W-1:0]  set_cnt_q;
  logic [SMP_W-1:0]  smp_cnt_q;
  logic [WIDTH-1:0]  pwm_cnt_q;

  // First enabled channel strictly after ptr, wrapping; ptr itself is the last candidate.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0]     ptr,
                                              input logic [CHANNELS-1:0] en);
    logic [CH_W-1:0] sel;
    logic [CH_W-1:0] c;
    sel = ptr;
    for (int unsigned i = CHANNELS; i >= 1; i--) begin
      c = CH_W'((32'(ptr) + i) % CHANNELS);
      if (en[c]) sel = c;
    end
    return sel;
  endfunction

  always_comb begin
    work_nxt = work_q;
    if (cmp) work_nxt = work_q | bit_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ptr_q     <= PtrReset;
      bit_q     <= Msb;
      work_q    <= '0;
      set_cnt_q <= '0;
      smp_cnt_q <= '0;
      pwm_cnt_q <= '0;
      mux_sel   <= '0;
      sample    <= 1'b0;
      dac_code  <= '0;
      pwm_out   <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      result    <= '0;
      result_ch <= '0;
    end else begin
      // The PWM runs independently of the conversion FSM.
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      pwm_out   <= (pwm_cnt_q < dac_code);
      valid     <= 1'b0;
      if (!go) begin
        state_q  <= StIdle;
        ptr_q    <= PtrReset;
        sample   <= 1'b0;
        dac_code <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (|ch_mask) begin
              state_q   <= StSample;
              mux_sel   <= next_ch(ptr_q, ch_mask);
              sample    <= 1'b1;
              busy      <= 1'b1;
              smp_cnt_q <= SmpReload;
            end
          end
          StSample: begin
            work_q    <= '0;
            bit_q     <= Msb;
            set_cnt_q <= SetReload;
            if (smp_cnt_q == '0) begin
              state_q  <= StConv;
              sample   <= 1'b0;
              dac_code <= Msb;
            end else begin
              smp_cnt_q <= smp_cnt_q - 1'b1;
            end
          end
          StConv: begin
            if (set_cnt_q == '0) begin
              work_q    <= work_nxt;
              set_cnt_q <= SetReload;
              if (bit_q[0]) begin
                state_q  <= StDone;
                dac_code <= '0;
              end else begin
                bit_q    <= bit_q >> 1;
                dac_code <= work_nxt | (bit_q >> 1);
              end
            end else begin
              set_cnt_q <= set_cnt_q - 1'b1;
            end
          end
          StDone: begin
            result    <= work_q;
            result_ch <= mux_sel;
            valid     <= 1'b1;
            ptr_q     <= mux_sel;
            if (|ch_mask) begin
              state_q   <= StSample;
              mux_sel   <= next_ch(mux_sel, ch_mask);
              sample    <= 1'b1;
              smp_cnt_q <= SmpReload;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_sar_scan.sv
// Scoreboard bench for pwm_sar_scan: stimulus predicts (channel, result) per conversion,
// a monitor pops on valid and also tracks the PWM output against a free-running counter.
module tb_pwm_sar_scan;

  localparam int W      = 8;
  localparam int NC     = 4;
  localparam int ST     = 4;
  localparam int SC     = 2;
  localparam int PERIOD = SC + W * ST + 1;

  logic          clk;
  logic          reset;
  logic          go;
  logic [NC-1:0] ch_mask;
  logic          cmp;
  logic [1:0]    mux_sel;
  logic          sample;
  logic [W-1:0]  dac_code;
  logic          pwm_out;
  logic          busy;
  logic          valid;
  logic [W-1:0]  result;
  logic [1:0]    result_ch;

  logic [W-1:0] vin [NC];

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] res;
  } exp_t;

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_cyc = 0;

  pwm_sar_scan #(
    .WIDTH      (W),
    .CHANNELS   (NC),
    .SETTLE     (ST),
    .SAMPLE_CYC (SC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .ch_mask   (ch_mask),
    .cmp       (cmp),
    .mux_sel   (mux_sel),
    .sample    (sample),
    .dac_code  (dac_code),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .valid     (valid),
    .result    (result),
    .result_ch (result_ch)
  );

  // Comparator modelled so that the search converges on the input value itself.
  assign cmp = (vin[mux_sel] >= dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Binary search for the largest code the comparator accepts.
  function automatic logic [W-1:0] sar_model(input logic [W-1:0] v);
    logic [W-1:0] w;
    logic [W-1:0] t;
    w = '0;
    for (int b = W - 1; b >= 0; b--) begin
      t = w | W'(1 << b);
      if (v >= t) w = t;
    end
    return w;
  endfunction

  function automatic logic [W-1:0] trial_code(input logic [W-1:0] v, input int k);
    logic [W-1:0] w;
    logic [W-1:0] t;
    w = '0;
    for (int i = 0; i < W; i++) begin
      t = w | W'(1 << (W - 1 - i));
      if (i == k) return t;
      if (v >= t) w = t;
    end
    return '0;
  endfunction

  function automatic int next_model(input int ptr, input logic [NC-1:0] m);
    for (int i = 1; i <= NC; i++) begin
      if (m[(ptr + i) % NC]) return (ptr + i) % NC;
    end
    return ptr;
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int   m_cnt;
    int   prev_cnt;
    int   prev_dac;
    bit   have_prev;
    exp_t e;
    m_cnt     = 0;
    have_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        m_cnt     = 0;
        have_prev = 1'b0;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << W);
        if (have_prev) check("pwm_out", 32'(pwm_out), 32'(prev_cnt < prev_dac));
        prev_cnt  = m_cnt;
        prev_dac  = int'(dac_code);
        have_prev = 1'b1;
        if (valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: got ch=%0d res=0x%0h, expected no valid (cycle %0d)",
                     result_ch, result, cyc);
          end else begin
            e = q.pop_front();
            check("result_ch", 32'(result_ch), 32'(e.ch));
            check("result", 32'(result), 32'(e.res));
            check("valid_time", cyc, exp_cyc);
            exp_cyc = exp_cyc + PERIOD;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (q.size() != 0 && t < budget) begin
      step();
      t++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic push_exp(input int c);
    q.push_back(exp_t'{ch: 2'(c), res: sar_model(vin[c])});
  endtask

  task automatic run_scan(input logic [NC-1:0] m, input int n);
    int p;
    p = NC - 1;
    for (int i = 0; i < n; i++) begin
      p = next_model(p, m);
      push_exp(p);
    end
    exp_cyc = cyc + 1 + PERIOD;
    ch_mask = m;
    go      = 1'b1;
    wait_drain(n * PERIOD + 80);
  endtask

  task automatic abort_scan();
    go = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sample", 32'(sample), 32'd0);
    check("abort_dac", 32'(dac_code), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    go      = 1'b0;
    ch_mask = '0;
    vin[0]  = 8'h00;
    vin[1]  = 8'hFF;
    vin[2]  = 8'h80;
    vin[3]  = 8'h5A;
    #1 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mux_sel", 32'(mux_sel), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_dac", 32'(dac_code), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    ch_mask = 4'b0001;
    go      = 1'b1;
    repeat (10) step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    check("pre_reset_dac", 32'(dac_code), 32'(trial_code(vin[0], 1)));
    #2 reset = 1'b0;
    #1;
    check("async_mux_sel", 32'(mux_sel), 32'd0);
    check("async_sample", 32'(sample), 32'd0);
    check("async_dac", 32'(dac_code), 32'd0);
    check("async_pwm", 32'(pwm_out), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_result", 32'(result), 32'd0);
    check("async_result_ch", 32'(result_ch), 32'd0);
    go = 1'b0;
    step();
    reset = 1'b1;
    repeat (10) step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sample", 32'(sample), 32'd0);

    // Full round-robin with wrap back to channel 0.
    run_scan(4'b1111, 5);
    abort_scan();

    // Sparse mask, then mask cleared while a conversion is in flight.
    run_scan(4'b1010, 4);
    ch_mask = '0;
    push_exp(1);
    wait_drain(PERIOD + 10);
    check("mask0_busy", 32'(busy), 32'd0);
    repeat (40) step();
    check("mask0_busy_late", 32'(busy), 32'd0);
    go = 1'b0;
    step();

    // Abort during trial 4 of channel 2; result must keep channel 1.
    push_exp(0);
    push_exp(1);
    exp_cyc = cyc + 1 + PERIOD;
    ch_mask = 4'b1111;
    go      = 1'b1;
    repeat (1 + SC + 2 * PERIOD + 3 * ST - 1 + 1) step();
    check("abort_mux_sel", 32'(mux_sel), 32'd2);
    check("abort_trial4", 32'(dac_code), 32'(trial_code(vin[2], 3)));
    check("abort_q_empty", 32'(q.size()), 32'd0);
    abort_scan();
    repeat (60) step();
    check("hold_result", 32'(result), 32'(sar_model(vin[1])));
    check("hold_result_ch", 32'(result_ch), 32'd1);
    run_scan(4'b1111, 1);
    abort_scan();

    // Trial-by-trial DAC sequence on a single channel.
    push_exp(3);
    exp_cyc = cyc + 1 + PERIOD;
    ch_mask = 4'b1000;
    go      = 1'b1;
    step();
    check("smp_sample0", 32'(sample), 32'd1);
    check("smp_busy", 32'(busy), 32'd1);
    check("smp_mux_sel", 32'(mux_sel), 32'd3);
    step();
    check("smp_sample1", 32'(sample), 32'd1);
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < ST; j++) begin
        step();
        check("trial_dac", 32'(dac_code), 32'(trial_code(vin[3], k)));
      end
    end
    check("conv_sample", 32'(sample), 32'd0);
    wait_drain(10);
    check("final_5a", 32'(result), 32'h5A);
    abort_scan();

    // Randomized scans.
    repeat (8) begin
      for (int c = 0; c < NC; c++) vin[c] = W'($urandom_range(0, 255));
      run_scan(NC'($urandom_range(1, 15)), int'($urandom_range(1, 4)));
      abort_scan();
    end

    // Idle with DAC code 0: the PWM output stays low.
    repeat (300) step();
    check("idle_pwm", 32'(pwm_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
